// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: FSM states, table depth and
// default timing constants.
package tone_sequencer_pkg;

  localparam int TABLE_DEPTH = 8;
  localparam int DEFAULT_DIV = 64;
  localparam int DEFAULT_GAP = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/tone_sequencer_tick_divider.sv
// Sample-tick divider: counts 0..DIV-1 while running, held at 0 by clr.
// tick_now flags the current terminal count; sample_tick is its registered form.
module tick_divider #(
  parameter int DIV = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run_next,
  output logic tick_now,
  output logic sample_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample_tick_q, sample_tick_d;

  always_comb begin
    cnt_d = '0;
    if (!clr && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
    // Predicting next cycle's tick keeps the output registered yet aligned.
    sample_tick_d = run_next && (cnt_d == LAST);
  end

  assign tick_now    = !clr && (cnt_q == LAST);
  assign sample_tick = sample_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      sample_tick_q <= sample_tick_d;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays up to eight {step, duration} notes from a small table into a sine NCO,
// with optional looping and silent gaps between notes.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int TABLE_BITS = 6,
  parameter int DUR_BITS   = 16,
  parameter int DIV        = DEFAULT_DIV,
  parameter int GAP        = DEFAULT_GAP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [TABLE_BITS-1:0] cfg_step,
  input  logic [DUR_BITS-1:0]   cfg_dur,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [3:0]            len,
  output logic [TABLE_BITS-1:0] step_out,
  output logic                  phase_clr,
  output logic                  sample_tick,
  output logic [2:0]            note_idx,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  localparam logic HAS_GAP = (GAP > 0);
  localparam logic [DUR_BITS-1:0] GAP_TICKS = DUR_BITS'(GAP);

  seq_state_e            state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [DUR_BITS-1:0]   dur_q, dur_d;
  logic [TABLE_BITS-1:0] step_tab_q [TABLE_DEPTH];
  logic [TABLE_BITS-1:0] step_tab_d [TABLE_DEPTH];
  logic [DUR_BITS-1:0]   dur_tab_q  [TABLE_DEPTH];
  logic [DUR_BITS-1:0]   dur_tab_d  [TABLE_DEPTH];
  logic [TABLE_BITS-1:0] step_q, step_d;
  logic                  phase_clr_q, phase_clr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tick_now;
  logic                  div_clr;
  logic                  run_next;
  logic                  last_note;
  seq_state_e            eon_state;
  logic [2:0]            eon_idx;
  logic [DUR_BITS-1:0]   eon_dur;

  always_comb begin
    step_tab_d = step_tab_q;
    dur_tab_d  = dur_tab_q;
    if (cfg_we && (state_q == ST_IDLE)) begin
      step_tab_d[cfg_addr] = cfg_step;
      dur_tab_d[cfg_addr]  = cfg_dur;
    end
  end

  // End-of-note decision; loop_en and len are taken live at this point.
  always_comb begin
    last_note = (({1'b0, idx_q} + 4'd1) >= len);
    eon_state = HAS_GAP ? ST_GAP : ST_LOAD;
    eon_idx   = idx_q + 3'd1;
    eon_dur   = HAS_GAP ? GAP_TICKS : '0;
    if (last_note) begin
      eon_idx = loop_en ? 3'd0 : idx_q;
      if (!loop_en) begin
        eon_state = ST_DONE;
        eon_dur   = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    case (state_q)
      ST_IDLE: begin
        dur_d = '0;
        if (start && !stop) begin
          idx_d   = 3'd0;
          state_d = (len == 4'd0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        dur_d   = dur_tab_q[idx_q];
        state_d = ST_PLAY;
        if (dur_tab_q[idx_q] == '0) begin
          state_d = eon_state;
          idx_d   = eon_idx;
          dur_d   = eon_dur;
        end
      end
      ST_PLAY: begin
        if (tick_now) begin
          dur_d = dur_q - 1'b1;
          if (dur_q == DUR_BITS'(1)) begin
            state_d = eon_state;
            idx_d   = eon_idx;
            dur_d   = eon_dur;
          end
        end
      end
      ST_GAP: begin
        if (tick_now) begin
          dur_d = dur_q - 1'b1;
          if (dur_q == DUR_BITS'(1)) state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        dur_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        dur_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      dur_d   = '0;
    end
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    step_d      = (state_d == ST_PLAY) ? step_tab_q[idx_d] : '0;
    phase_clr_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  assign div_clr  = !((state_q == ST_PLAY) || (state_q == ST_GAP));
  assign run_next = (state_d == ST_PLAY) || (state_d == ST_GAP);

  tick_divider #(.DIV(DIV)) u_tick_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (div_clr),
    .run_next    (run_next),
    .tick_now    (tick_now),
    .sample_tick (sample_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dur_q       <= '0;
      step_q      <= '0;
      phase_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        step_tab_q[i] <= '0;
        dur_tab_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dur_q       <= dur_d;
      step_q      <= step_d;
      phase_clr_q <= phase_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_tab_q  <= step_tab_d;
      dur_tab_q   <= dur_tab_d;
    end
  end

  assign step_out  = step_q;
  assign phase_clr = phase_clr_q;
  assign note_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer with DIV=4, GAP=1: a note-level model expands each
// sequence into per-cycle expected outputs that are compared cycle by cycle.
module tb_tone_sequencer;

  localparam int TB = 6;
  localparam int DB = 16;
  localparam int DIV = 4;
  localparam int GAP = 1;
  localparam int W = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [TB-1:0] cfg_step = '0;
  logic [DB-1:0] cfg_dur = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [3:0]    len = '0;
  logic [TB-1:0] step_out;
  logic          phase_clr;
  logic          sample_tick;
  logic [2:0]    note_idx;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad = 0;
  int sh_step [8];
  int sh_dur  [8];
  logic [W-1:0] exp_q[$];

  tone_sequencer #(.TABLE_BITS(TB), .DUR_BITS(DB), .DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_step(cfg_step), .cfg_dur(cfg_dur), .start(start), .stop(stop),
    .loop_en(loop_en), .len(len), .step_out(step_out), .phase_clr(phase_clr),
    .sample_tick(sample_tick), .note_idx(note_idx), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input int b, input int d, input int p,
                                        input int t, input int idx, input int s);
    logic [W-1:0] v;
    v = {b[0], d[0], p[0], t[0], idx[2:0], s[TB-1:0]};
    return v;
  endfunction

  function automatic logic [W-1:0] observed();
    return {busy, done, phase_clr, sample_tick, note_idx, step_out};
  endfunction

  // Expected trace: each note is a LOAD cycle, dur*DIV playing cycles, then
  // GAP*DIV silent cycles unless it is the final note of the final pass.
  task automatic build_trace(input int n_len, input int passes);
    exp_q.delete();
    if (n_len == 0) begin
      exp_q.push_back(pack(1, 1, 0, 0, 0, 0));
      return;
    end
    for (int p = 0; p < passes; p++) begin
      for (int n = 0; n < n_len; n++) begin
        int nxt;
        exp_q.push_back(pack(1, 0, 1, 0, n, 0));
        for (int k = 0; k < sh_dur[n] * DIV; k++)
          exp_q.push_back(pack(1, 0, 0, (k % DIV == DIV - 1) ? 1 : 0, n, sh_step[n]));
        if (n == n_len - 1 && p == passes - 1) break;
        nxt = (n == n_len - 1) ? 0 : n + 1;
        for (int k = 0; k < GAP * DIV; k++)
          exp_q.push_back(pack(1, 0, 0, (k % DIV == DIV - 1) ? 1 : 0, nxt, 0));
      end
    end
    exp_q.push_back(pack(1, 1, 0, 0, n_len - 1, 0));
  endtask

  task automatic write_slot(input int a, input int s, input int d);
    cfg_we = 1'b1;
    cfg_addr = a[2:0];
    cfg_step = s[TB-1:0];
    cfg_dur = d[DB-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    sh_step[a] = s;
    sh_dur[a] = d;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic [W-1:0] o;
      @(negedge clk);
      o = observed();
      o[TB+2:TB] = 3'd0;
      total++;
      if (o !== '0) begin
        bad++;
        $display("FAIL %s idle cycle %0d: got %h expected 0 (idx ignored)", name, i, o);
      end
    end
  endtask

  // Called just after a negedge; start is sampled at the next posedge.
  task automatic run_seq(input string name, input int drop_loop_at,
                         input int cfg_at, input int stop_at);
    int c;
    c = 0;
    start = 1'b1;
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      @(negedge clk);
      start = 1'b0;
      cfg_we = 1'b0;
      c++;
      e = exp_q.pop_front();
      total++;
      if (observed() !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, observed(), e);
      end
      if (c == drop_loop_at) loop_en = 1'b0;
      if (c == cfg_at) begin
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_step = 6'd33;
        cfg_dur = 16'd7;
      end
      if (c == stop_at) begin
        stop = 1'b1;
        exp_q.delete();
      end
    end
    @(negedge clk);
    stop = 1'b0;
    cfg_we = 1'b0;
    total++;
    if ({busy, done, phase_clr, sample_tick, step_out} !== '0) begin
      bad++;
      $display("FAIL %s end cycle %0d: got %h expected idle", name, c + 1, observed());
    end
    check_idle(name, 2);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      sh_step[i] = 0;
      sh_dur[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (observed() !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h expected 0", observed());
    end
    // A cleared table gives slot 0 a zero duration: LOAD then straight to DONE.
    len = 4'd1;
    build_trace(1, 1);
    run_seq("reset_table", -1, -1, -1);
    write_slot(0, 5, 3);
    build_trace(1, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (observed() !== '0) begin
      bad++;
      $display("FAIL reset_mid_play: got %h expected 0", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sh_step[i] = 0;
      sh_dur[i] = 0;
    end
    check_idle("reset_after_release", 6);
  endtask

  task automatic test_single_note();
    write_slot(0, 5, 3);
    len = 4'd1;
    loop_en = 1'b0;
    build_trace(1, 1);
    run_seq("single_note", -1, -1, -1);
  endtask

  task automatic test_two_notes();
    write_slot(0, 5, 2);
    write_slot(1, 9, 1);
    len = 4'd2;
    build_trace(2, 1);
    run_seq("two_notes", -1, -1, -1);
  endtask

  task automatic test_zero_dur();
    write_slot(0, 5, 1);
    write_slot(1, 12, 0);
    write_slot(2, 7, 1);
    len = 4'd3;
    build_trace(3, 1);
    run_seq("zero_dur", -1, -1, -1);
  endtask

  task automatic test_len_zero();
    len = 4'd0;
    build_trace(0, 1);
    run_seq("len_zero", -1, -1, -1);
  endtask

  task automatic test_stop();
    write_slot(0, 5, 3);
    len = 4'd1;
    build_trace(1, 1);
    run_seq("stop_mid_play", -1, -1, 7);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    total++;
    if ({busy, done, phase_clr, step_out} !== '0) begin
      bad++;
      $display("FAIL start_with_stop: got %h expected idle", observed());
    end
    check_idle("start_with_stop", 3);
  endtask

  // Two-note loop (22 cycles per pass); loop_en drops during note 0 of
  // pass two, and a table write mid-sequence must have no effect.
  task automatic test_loop();
    write_slot(0, 5, 2);
    write_slot(1, 9, 1);
    len = 4'd2;
    loop_en = 1'b1;
    build_trace(2, 2);
    run_seq("loop_two_pass", 25, 5, -1);
    loop_en = 1'b0;
    len = 4'd1;
    build_trace(1, 1);
    run_seq("cfg_while_busy", -1, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int n;
      for (int a = 0; a < 8; a++)
        write_slot(a, $urandom_range(1, 63), $urandom_range(0, 3));
      n = $urandom_range(1, 8);
      len = n[3:0];
      loop_en = 1'b0;
      build_trace(n, 1);
      run_seq("random_seq", -1, -1, -1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_note();
    test_two_notes();
    test_zero_dur();
    test_len_zero();
    test_stop();
    test_loop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter TABLE_BITS, default 6, NCO step width, matching the sine NCO.
REQ-002 SHALL have parameter DUR_BITS, default 16, note duration width in sample ticks.
REQ-003 SHALL have parameter DIV, default 64, clocks per sample tick (>=2).
REQ-004 SHALL have parameter GAP, default 1, silent sample ticks between consecutive notes (0 allowed).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have config ports: cfg_we  in  1  table write strobe; cfg_addr  in  3  note slot 0..7; cfg_step  in  TABLE_BITS  note step; cfg_dur  in  DUR_BITS  note duration.
REQ-007 SHALL have control ports: start  in  1  begin sequence; stop  in  1  abort; loop_en  in  1  repeat sequence; len  in  4  notes in sequence, 0..8.
REQ-008 SHALL have NCO ports: step_out  out  TABLE_BITS  step to NCO; phase_clr  out  1  one-cycle NCO phase reset pulse, active high; sample_tick  out  1  sample strobe.
REQ-009 SHALL have status ports: note_idx  out  3  current slot; busy  out  1  sequence active; done  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL hold an 8-entry table {step, dur}; cfg_we writes slot cfg_addr only in IDLE; writes in any other state are ignored.
REQ-011 SHALL implement states IDLE, LOAD, PLAY, GAP, DONE; busy = (state != IDLE).
REQ-012 IDLE: start=1, stop=0, len>=1 -> LOAD with note_idx=0; start with len=0 -> DONE; start ignored in all other states.
REQ-013 LOAD (one cycle): phase_clr=1, step_out=0, load duration counter from table[note_idx]; next PLAY, or if dur=0 skip the note as the end-of-note rule (REQ-016) without entering PLAY.
REQ-014 PLAY: step_out=table[note_idx].step; divider counts 0..DIV-1 from 0 at PLAY/GAP entry; sample_tick=1 when divider=DIV-1.
REQ-015 Duration counter decrements on each sample_tick in PLAY; the tick taking it to 0 ends the note.
REQ-016 End of note: if note_idx<len-1 -> GAP (GAP>0) or LOAD (GAP=0), note_idx+1; if last note and loop_en=1 -> GAP/LOAD with note_idx=0; if last and loop_en=0 -> DONE (no trailing gap).
REQ-017 GAP: step_out=0, sample_tick continues; after GAP ticks -> LOAD.
REQ-018 DONE (one cycle): done=1, step_out=0; next IDLE.
REQ-019 stop=1 in any non-IDLE state -> IDLE next cycle, step_out=0, no done pulse; stop wins over simultaneous start.
REQ-020 step_out=0 and sample_tick=0 in IDLE, LOAD, DONE.
REQ-021 loop_en and len sampled at each end-of-note decision; table contents fixed while busy.
REQ-022 All outputs registered; phase_clr aligns with the LOAD cycle so the NCO sees the new step with zero phase.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, step_out=0, phase_clr=0, sample_tick=0, note_idx=0, busy=0, done=0, divider and duration counters=0.
REQ-024 Table contents SHALL be reset to step=0, dur=0.
REQ-025 Reset deassertion mid-sequence SHALL leave the block in IDLE; no done pulse.

Structure
REQ-026 Shared package SHALL hold the state enumeration, table depth (8), and default DIV/GAP constants.
REQ-027 One sub-module SHALL be used: tick_divider (DIV counter, clear input, tick output); the sequencer FSM and table stay in tone_sequencer.

Verification (DIV=4, GAP=1)
REQ-028 Reset: assert rst_n=0 mid-PLAY -> all outputs 0 immediately, busy=0 after release, no done.
REQ-029 Single note slot0 {step=5,dur=3}, len=1, start at cycle 0 -> phase_clr at cycle 1, step_out=5 cycles 2..13, sample_tick at 5, 9, 13, done at 14, busy=0 at 15.
REQ-030 Two notes {5,2},{9,1}, len=2 -> step 5 for 8 cycles, step 0 for 4 gap cycles, LOAD, step 9 for 4 cycles, done; note_idx 0 then 1.
REQ-031 Zero-duration: slot1 dur=0 in len=3 -> slot1 never drives step_out, note_idx goes 0,1,2, sequence completes with done.
REQ-032 stop at cycle 7 of REQ-029 stimulus -> step_out=0 and busy=0 at cycle 8, no done; start with stop same cycle -> stays IDLE.
REQ-033 loop_en=1, len=2 -> note_idx wraps 1->0 with gap; clear loop_en during note 0 -> exactly one more pass then done; cfg_we while busy -> table unchanged.
